// File: rtl/lcd_text_scheduler.sv
// lcd_text_scheduler
//   Feeds an HD44780-style character controller from a 2x16 text buffer.
//   After reset it sends the init command list once, then re-sends a whole
//   display line (address command + 16 characters) whenever any character
//   of that line has been written.
//
// Ports:
//   iCLK, iRST_N        clock, asynchronous active-low reset
//   iWR_EN/ADDR/CHAR    host character write; ADDR[4] = line, ADDR[3:0] = column
//   oLCD_DATA/RS/START  byte, register select (0 cmd, 1 data) and start to controller
//   iLCD_DONE           controller done level
//   oINIT_DONE          sticky flag, set once the init list has been sent
//   oBUSY               high whenever the scheduler is not idle
module lcd_text_scheduler #(
  parameter int unsigned DLY_CYCLES = 262142,
  parameter int unsigned INIT_CMDS  = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iWR_EN,
  input  logic [4:0] iWR_ADDR,
  input  logic [7:0] iWR_CHAR,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_START,
  input  logic       iLCD_DONE,
  output logic       oINIT_DONE,
  output logic       oBUSY
);

  localparam int unsigned CNT_W = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DLY_CYCLES - 1);
  localparam logic [3:0]       INIT_LAST = 4'(INIT_CMDS - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ADDR, ST_CHARS} state_t;
  typedef enum logic [1:0] {PH_ISSUE, PH_WAIT_ACK, PH_WAIT_DONE, PH_DELAY} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             line_q, line_d;
  logic             last_q, last_d;
  logic             init_done_q, init_done_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             start_q, start_d;
  logic [1:0]       dirty_q, dirty_clr, dirty_set;
  logic [7:0]       buffer [32];
  logic             sel;

  function automatic logic [7:0] init_cmd(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h38;
      4'd1:    return 8'h0C;
      4'd2:    return 8'h01;
      4'd3:    return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_INIT;
      phase_q     <= PH_ISSUE;
      idx_q       <= '0;
      cnt_q       <= '0;
      line_q      <= 1'b0;
      last_q      <= 1'b1;
      init_done_q <= 1'b0;
      data_q      <= '0;
      rs_q        <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      last_q      <= last_d;
      init_done_q <= init_done_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      start_q     <= start_d;
    end
  end

  // Round-robin only matters when both lines are dirty; last_q resets to 1
  // so line 0 is served first after reset.
  always_comb begin
    sel = (dirty_q == 2'b11) ? ~last_q : dirty_q[1];
  end

  // Next-state logic: top-level state plus per-byte handshake phase
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    last_d      = last_q;
    init_done_d = init_done_q;
    if (state_q == ST_IDLE) begin
      phase_d = PH_ISSUE;
      if (dirty_q != 2'b00) begin
        state_d = ST_ADDR;
        line_d  = sel;
        last_d  = sel;
      end
    end else begin
      case (phase_q)
        PH_ISSUE:     phase_d = PH_WAIT_ACK;
        PH_WAIT_ACK:  if (!iLCD_DONE) phase_d = PH_WAIT_DONE;
        PH_WAIT_DONE: begin
          if (iLCD_DONE) begin
            phase_d = PH_DELAY;
            cnt_d   = '0;
          end
        end
        PH_DELAY: begin
          if (cnt_q == CNT_LAST) begin
            phase_d = PH_ISSUE;
            case (state_q)
              ST_INIT: begin
                if (idx_q == INIT_LAST) begin
                  state_d     = ST_IDLE;
                  idx_d       = '0;
                  init_done_d = 1'b1;
                end else begin
                  idx_d = idx_q + 4'd1;
                end
              end
              ST_ADDR: begin
                state_d = ST_CHARS;
                idx_d   = '0;
              end
              ST_CHARS: begin
                if (idx_q == 4'd15) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                end else begin
                  idx_d = idx_q + 4'd1;
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: phase_d = PH_ISSUE;
      endcase
    end
  end

  // Output logic: byte/RS are loaded only at ISSUE so they stay stable
  // through the whole handshake and settle delay.
  always_comb begin
    data_d    = data_q;
    rs_d      = rs_q;
    start_d   = start_q;
    dirty_clr = '0;
    if (phase_q == PH_ISSUE && state_q != ST_IDLE) begin
      start_d = 1'b1;
      case (state_q)
        ST_INIT: begin
          data_d = init_cmd(idx_q);
          rs_d   = 1'b0;
        end
        ST_ADDR: begin
          data_d            = line_q ? 8'hC0 : 8'h80;
          rs_d              = 1'b0;
          dirty_clr[line_q] = 1'b1;
        end
        default: begin
          data_d = buffer[{line_q, idx_q}];
          rs_d   = 1'b1;
        end
      endcase
    end
    if (phase_q == PH_WAIT_DONE && iLCD_DONE) start_d = 1'b0;
  end

  always_comb begin
    dirty_set = '0;
    if (iWR_EN) dirty_set[iWR_ADDR[4]] = 1'b1;
  end

  // Text buffer and dirty flags; a write in the clear cycle keeps the line dirty
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned i = 0; i < 32; i++) buffer[i] <= 8'h20;
      dirty_q <= 2'b11;
    end else begin
      if (iWR_EN) buffer[iWR_ADDR] <= iWR_CHAR;
      dirty_q <= (dirty_q & ~dirty_clr) | dirty_set;
    end
  end

  assign oLCD_DATA  = data_q;
  assign oLCD_RS    = rs_q;
  assign oLCD_START = start_q;
  assign oINIT_DONE = init_done_q;
  assign oBUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_text_scheduler.sv
module tb_lcd_text_scheduler;

  localparam int unsigned DLY = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_start, init_done, busy;
  logic       lcd_done = 1'b0;

  always #5 clk = ~clk;

  lcd_text_scheduler #(.DLY_CYCLES(DLY), .INIT_CMDS(4)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iWR_EN(wr_en), .iWR_ADDR(wr_addr), .iWR_CHAR(wr_char),
    .oLCD_DATA(lcd_data), .oLCD_RS(lcd_rs), .oLCD_START(lcd_start), .iLCD_DONE(lcd_done),
    .oINIT_DONE(init_done), .oBUSY(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: display text, dirty lines, progress of the
  // current line refresh, and a log of every byte seen on the bus.
  logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  logic [7:0] m_buf [32];
  logic [1:0] m_dirty, m_dirty_before;
  int         m_k, m_col;
  logic       m_line, m_last;
  logic [7:0] tr_data [1024];
  logic       tr_rs [1024];
  int         tr_count = 0;
  int         hold_extra = 0;

  logic       p_en = 1'b0;
  logic [4:0] p_addr = '0;
  logic [7:0] p_char = '0;

  always @(posedge clk) begin
    p_en   <= wr_en && rst_n;
    p_addr <= wr_addr;
    p_char <= wr_char;
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_dirty = 2'b11;
    m_dirty_before = 2'b11;
    m_k = 0;
    m_col = 16;
    m_last = 1'b1;
    m_line = 1'b0;
  endtask

  task automatic model_transfer();
    logic [7:0] ed;
    logic       er;
    logic       s;
    chk($sformatf("byte%0d_init_done", tr_count), 32'(init_done), 32'(m_k >= 4));
    if (m_k < 4) begin
      ed = init_tab[m_k];
      er = 1'b0;
      m_k++;
    end else if (m_col == 16) begin
      chk($sformatf("byte%0d_refresh_wanted", tr_count), 32'(m_dirty_before != 2'b00), 32'd1);
      s = (m_dirty_before == 2'b11) ? ~m_last : m_dirty_before[1];
      ed = s ? 8'hC0 : 8'h80;
      er = 1'b0;
      m_line = s;
      m_last = s;
      m_dirty[s] = 1'b0;
      m_col = 0;
    end else begin
      ed = m_buf[5'(int'(m_line) * 16 + m_col)];
      er = 1'b1;
      m_col++;
    end
    chk($sformatf("byte%0d_data", tr_count), 32'(lcd_data), 32'(ed));
    chk($sformatf("byte%0d_rs", tr_count), 32'(lcd_rs), 32'(er));
    tr_data[tr_count] = lcd_data;
    tr_rs[tr_count] = lcd_rs;
    tr_count++;
  endtask

  // Compare process plus controller model (done 20 cycles after start rises,
  // optionally keeping the stale done high for hold_extra cycles).
  initial begin
    logic       sp = 1'b0;
    logic       cbusy = 1'b0;
    int         cc = 0;
    int         hold_chg = 0;
    logic [7:0] ld = '0;
    logic       lr = 1'b0;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        sp = 1'b0; cbusy = 1'b0; cc = 0; lcd_done = 1'b0; hold_chg = 0;
        ld = lcd_data; lr = lcd_rs;
      end else begin
        if (sp && !lcd_start)
          chk($sformatf("byte%0d_start_drop_ctl_idle", tr_count), 32'(cbusy), 32'd0);
        if (lcd_start && !sp) begin
          chk($sformatf("byte%0d_prev_hold", tr_count), 32'(hold_chg), 32'd0);
          hold_chg = 0;
          model_transfer();
        end else if (lcd_data !== ld || lcd_rs !== lr) begin
          hold_chg++;
        end
        ld = lcd_data;
        lr = lcd_rs;
        m_dirty_before = m_dirty;
        if (p_en) begin
          m_buf[p_addr] = p_char;
          m_dirty[p_addr[4]] = 1'b1;
        end
        if (lcd_start && !sp) begin
          cbusy = 1'b1;
          cc = 0;
          if (hold_extra == 0) lcd_done = 1'b0;
        end else if (cbusy) begin
          cc++;
          if (cc == hold_extra) lcd_done = 1'b0;
          if (cc == 20) begin
            lcd_done = 1'b1;
            cbusy = 1'b0;
          end
        end
        sp = lcd_start;
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [7:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_tr(input int target);
    int n = 0;
    while (tr_count < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (tr_count < target) begin
      vectors++; miscompares++;
      $display("FAIL wait_tr: got %0d transfers required %0d", tr_count, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 4000) begin
      @(negedge clk);
      n++;
      if (!busy) quiet++; else quiet = 0;
    end
    if (quiet < 3) begin
      vectors++; miscompares++;
      $display("FAIL %s_idle_timeout: busy=%0b required 0", name, busy);
    end else begin
      chk({name, "_model_done"}, {28'd0, m_dirty, 1'(m_col == 16), 1'(m_k == 4)}, 32'h3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(lcd_data), 32'h00);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_start", 32'(lcd_start), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;

    // Init then both lines of blanks
    wait_tr(38);
    wait_idle("init");
    chk("init_count", 32'(tr_count), 32'd38);
    chk("init_b0", 32'(tr_data[0]), 32'h38);
    chk("init_b1", 32'(tr_data[1]), 32'h0C);
    chk("init_b2", 32'(tr_data[2]), 32'h01);
    chk("init_b3", 32'(tr_data[3]), 32'h06);
    chk("init_addr0", 32'(tr_data[4]), 32'h80);
    chk("init_c0", 32'(tr_data[5]), 32'h20);
    chk("init_c0_rs", 32'(tr_rs[5]), 32'd1);
    chk("init_addr1", 32'(tr_data[21]), 32'hC0);
    chk("init_last", 32'(tr_data[37]), 32'h20);
    chk("init_done_flag", 32'(init_done), 32'd1);

    // Single write -> one line 0 refresh
    s = tr_count;
    wr(5'h03, 8'h41);
    wait_idle("one");
    chk("one_count", 32'(tr_count - s), 32'd17);
    chk("one_addr", 32'(tr_data[s]), 32'h80);
    chk("one_c2", 32'(tr_data[s + 3]), 32'h20);
    chk("one_c3", 32'(tr_data[s + 4]), 32'h41);

    // Write during refresh to an already-sent column -> second pass
    s = tr_count;
    wr(5'h0F, 8'h43);
    wait_tr(s + 12);
    wr(5'h01, 8'h42);
    wait_idle("mid");
    chk("mid_count", 32'(tr_count - s), 32'd34);
    chk("mid_p1_c1", 32'(tr_data[s + 2]), 32'h20);
    chk("mid_p1_c15", 32'(tr_data[s + 16]), 32'h43);
    chk("mid_p2_addr", 32'(tr_data[s + 17]), 32'h80);
    chk("mid_p2_c1", 32'(tr_data[s + 19]), 32'h42);

    // Back-to-back writes to line 1 then line 0
    s = tr_count;
    wr(5'h10, 8'h44);
    wr(5'h00, 8'h45);
    wait_idle("b2b");
    chk("b2b_count", 32'(tr_count - s), 32'd34);
    chk("b2b_first", 32'(tr_data[s]), 32'hC0);
    chk("b2b_l1c0", 32'(tr_data[s + 1]), 32'h44);
    chk("b2b_second", 32'(tr_data[s + 17]), 32'h80);
    chk("b2b_l0c0", 32'(tr_data[s + 18]), 32'h45);

    // Both lines dirty after a line 1 refresh -> line 0 next
    s = tr_count;
    wr(5'h15, 8'h46);
    wait_tr(s + 6);
    wr(5'h00, 8'h47);
    wr(5'h1F, 8'h48);
    wait_idle("rr");
    chk("rr_count", 32'(tr_count - s), 32'd51);
    chk("rr_first", 32'(tr_data[s]), 32'hC0);
    chk("rr_second", 32'(tr_data[s + 17]), 32'h80);
    chk("rr_l0c0", 32'(tr_data[s + 18]), 32'h47);
    chk("rr_third", 32'(tr_data[s + 34]), 32'hC0);
    chk("rr_l1c15", 32'(tr_data[s + 50]), 32'h48);

    // Stale done held high well past each ISSUE
    hold_extra = 6;
    s = tr_count;
    wr(5'h08, 8'h49);
    wait_idle("hold");
    hold_extra = 0;
    chk("hold_count", 32'(tr_count - s), 32'd17);
    chk("hold_c8", 32'(tr_data[s + 9]), 32'h49);

    // Reset in the middle of a character transfer
    s = tr_count;
    wr(5'h12, 8'h4A);
    wait_tr(s + 5);
    n = 0;
    while (!lcd_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst2_start_before", 32'(lcd_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_start", 32'(lcd_start), 32'd0);
    chk("rst2_data", 32'(lcd_data), 32'h00);
    chk("rst2_busy", 32'(busy), 32'd1);
    chk("rst2_init_done", 32'(init_done), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    s = tr_count;
    wait_tr(s + 1);
    chk("rst2_first", 32'(tr_data[s]), 32'h38);
    chk("rst2_first_rs", 32'(tr_rs[s]), 32'd0);
    wait_idle("rst2");
    chk("rst2_count", 32'(tr_count - s), 32'd38);
    chk("rst2_l0c3_blank", 32'(tr_data[s + 8]), 32'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_text_scheduler.md
Name: lcd_text_scheduler

Overview:
- Upstream of the LCD character controller (start/done write engine). Replaces the fixed-ROM sequencer with a 32-character text buffer that host logic writes at any time.
- Runs the HD44780 init sequence once after reset.
- Re-sends a whole display line whenever any character in that line changes.
- Drives one byte per transfer over the controller's iDATA/iRS/iStart/oDone handshake, with a settle delay after each byte.

Parameters:
- DLY_CYCLES, 262142, idle cycles after each controller done (~5.2 ms at 50 MHz); benches use 8.
- INIT_CMDS, 4, number of init commands sent, in order: 0x38, 0x0C, 0x01, 0x06.

Ports:
- iCLK  in  1  system clock (50 MHz)
- iRST_N  in  1  asynchronous active-low reset
- iWR_EN  in  1  host write strobe, one character per cycle, always accepted
- iWR_ADDR  in  5  [4] = line (0 top, 1 bottom), [3:0] = column
- iWR_CHAR  in  8  ASCII code to store
- oLCD_DATA  out  8  byte to controller iDATA
- oLCD_RS  out  1  to controller iRS; 0 = command, 1 = data
- oLCD_START  out  1  to controller iStart
- iLCD_DONE  in  1  from controller oDone
- oINIT_DONE  out  1  high once the init sequence has finished; sticky until reset
- oBUSY  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset is asynchronous active-low on iRST_N; clock is iCLK.
- Reset values:
  - oLCD_DATA = 0, oLCD_RS = 0, oLCD_START = 0, oINIT_DONE = 0, oBUSY = 1.
  - All 32 buffer bytes = 0x20; dirty[1:0] = 2'b11; FSM = INIT.
- Buffer: 32x8 registers. A write takes effect on the iCLK edge where iWR_EN = 1 and sets dirty[iWR_ADDR[4]]. A buffer byte is sampled at the moment its transfer is issued, so later writes are never lost.
- Transfer micro-sequence, used for every byte:
  - ISSUE: load oLCD_DATA/oLCD_RS, set oLCD_START = 1.
  - WAIT_ACK: wait for iLCD_DONE = 0. This ignores the stale done level left over from the previous byte.
  - WAIT_DONE: wait for iLCD_DONE = 1, then set oLCD_START = 0.
  - DELAY: count 0..DLY_CYCLES-1, then go to NEXT.
  - oLCD_DATA/oLCD_RS hold stable from ISSUE through the end of DELAY.
- Top-level FSM:
  - INIT: send INIT_CMDS commands (RS = 0) in order. After the last DELAY, set oINIT_DONE = 1 and go to IDLE.
  - IDLE: if any dirty bit is set, select a line:
    - Only one line dirty: take that line.
    - Both dirty: take the line not refreshed last (round-robin); line 0 after reset.
  - ADDR: clear dirty[line] in the same cycle as its ISSUE, then send command 0x80 (line 0) or 0xC0 (line 1).
  - CHARS: send buffer[line*16 + col] with RS = 1 for col 0..15, then return to IDLE.
- Dirty-bit rules:
  - A write to the same line in the clear cycle wins: dirty stays 1.
  - A write during a refresh re-sets dirty, so the line is sent again afterwards, even if the written column was already sent.
- Host writes during INIT are accepted and buffered. Both lines are still dirty, so they are shown after INIT.
- Reset mid-transfer: all state returns to reset values immediately and oLCD_START drops asynchronously. The full INIT reruns.
- Bus count per line refresh is 17 transfers. INIT is INIT_CMDS transfers.
- No back-pressure on the host; writes never stall.

Test Plan:
- Reset, controller model (done 20 cycles after start rising edge), DLY_CYCLES = 8 -> bytes 0x38, 0x0C, 0x01, 0x06 with RS = 0; oINIT_DONE rises after the 4th delay; then 0x80 + 16×0x20 (RS = 1), 0xC0 + 16×0x20; oBUSY = 0 afterwards.
- In IDLE, write 'A' (0x41) to addr 5'h03 -> exactly one refresh: 0x80, then 0x20, 0x20, 0x20, 0x41, 0x20 ×12; line 1 not sent.
- During a line 0 refresh at col 10, write 0x42 to addr 5'h01 -> current pass completes; a second line 0 pass follows with 0x42 at col 1.
- Write to addr 5'h10 and 5'h00 in consecutive cycles in IDLE, right after a line 0 refresh -> line 1 (0xC0) is sent before line 0 (round-robin).
- Hold iLCD_DONE = 1 from the previous byte when ISSUE occurs -> oLCD_START stays 1 until done goes 0, then 1 again; no byte is skipped.
- Assert iRST_N = 0 mid-CHARS -> oLCD_START = 0 immediately; after release, the 0x38 init command is the first byte issued.
